dmem_port_arbiter: RTL

Two-requester arbiter sharing the pipelined RISC-V core's single data-memory port between the CPU MEM stage and a DMA/debug loader port. The loader preloads arrays such as the sort input at 0x200 and drains results. Fixed CPU priority with a bounded-wait guarantee for DMA. Sits between `RISC_V_Processor_Pipelined` MEM-stage signals (`MemWrite_M`, `res_M`, `WriteData_M`) and `Data_Memory`. Its stall output feeds the hazard unit.

---
 rtl/dmem_arb_pkg.sv | 28 ++
 rtl/dmem_arb_wait_counter.sv | 27 ++
 rtl/dmem_port_arbiter.sv | 106 ++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory port arbiter.
// Owner encoding, byte-enable patterns and the alignment check.
package dmem_arb_pkg;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

    // Only word and halfword patterns carry alignment constraints; byte lanes never fault.
    function automatic logic is_misaligned(input logic [1:0] addr, input logic [3:0] be);
        logic mis;
        mis = 1'b0;
        case (be)
            BE_WORD:                mis = (addr != 2'b00);
            BE_HALF_LO, BE_HALF_HI: mis = addr[0];
            BE_BYTE0:               mis = 1'b0;
            default:                mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_arb_wait_counter.sv
// Saturating count of consecutive denied DMA cycles; force_dma asserts
// once the bound is reached so DMA wins the next arbitration.
module dmem_arb_wait_counter #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic dma_req,
    input  logic dma_gnt,
    output logic force_dma
);

    logic [3:0] wait_cnt;

    assign force_dma = (wait_cnt == 4'(MAX_WAIT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (!dma_req || dma_gnt) begin
            wait_cnt <= '0;
        end else if (!force_dma) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory port between the CPU MEM stage and a
// DMA/debug loader: CPU priority with a bounded wait for DMA.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [3:0]        cpu_be,
    input  logic [31:0]       cpu_wdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [3:0]        dma_be,
    input  logic [31:0]       dma_wdata,
    output logic              cpu_gnt,
    output logic              dma_gnt,
    output logic              cpu_rvalid,
    output logic              dma_rvalid,
    output logic [31:0]       cpu_rdata,
    output logic [31:0]       dma_rdata,
    output logic              cpu_err,
    output logic              dma_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              stall_cpu
);

    logic              force_dma;
    logic              gnt_any;
    logic              mis;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [3:0]        sel_be;
    logic [31:0]       sel_wdata;
    owner_t            rsp_owner;
    logic              rsp_pend;
    logic              rsp_err;

    dmem_arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait (
        .clk       (clk),
        .rst       (rst),
        .dma_req   (dma_req),
        .dma_gnt   (dma_gnt),
        .force_dma (force_dma)
    );

    // Grants are qualified by rst so every output reads 0 while in reset.
    assign dma_gnt   = rst & dma_req & (~cpu_req | force_dma);
    assign cpu_gnt   = rst & cpu_req & ~dma_gnt;
    assign gnt_any   = cpu_gnt | dma_gnt;
    assign stall_cpu = rst & cpu_req & ~cpu_gnt;

    always_comb begin
        sel_we    = cpu_we;
        sel_addr  = cpu_addr;
        sel_be    = cpu_be;
        sel_wdata = cpu_wdata;
        if (dma_gnt) begin
            sel_we    = dma_we;
            sel_addr  = dma_addr;
            sel_be    = dma_be;
            sel_wdata = dma_wdata;
        end
    end

    assign mis       = is_misaligned(sel_addr[1:0], sel_be);
    assign mem_en    = gnt_any & ~mis;
    assign mem_we    = mem_en & sel_we;
    assign mem_addr  = mem_en ? sel_addr  : '0;
    assign mem_be    = mem_en ? sel_be    : '0;
    assign mem_wdata = mem_en ? sel_wdata : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_pend  <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_owner <= OWN_CPU;
        end else begin
            rsp_pend <= gnt_any & (~sel_we | mis);
            rsp_err  <= gnt_any & mis;
            if (gnt_any) begin
                rsp_owner <= dma_gnt ? OWN_DMA : OWN_CPU;
            end
        end
    end

    assign cpu_rvalid = rsp_pend & (rsp_owner == OWN_CPU);
    assign dma_rvalid = rsp_pend & (rsp_owner == OWN_DMA);
    assign cpu_err    = cpu_rvalid & rsp_err;
    assign dma_err    = dma_rvalid & rsp_err;
    assign cpu_rdata  = (cpu_rvalid & ~rsp_err) ? mem_rdata : '0;
    assign dma_rdata  = (dma_rvalid & ~rsp_err) ? mem_rdata : '0;

endmodule
